// File: rtl/tlb_maint_ctrl_pkg.sv
// Shared types for the TLB maintenance sequencer: op codes, request/response
// records and the INVTLB operand limit.
// No ports; imported by the interface, the LFSR and the controller.
package tlb_maint_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_SRCH = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_FILL = 3'd3,
    OP_INV  = 3'd4
  } TlbMaintOpE;

  // Largest INVTLB sub-op the MMU understands; anything above is rejected.
  localparam logic [4:0] INVTLB_OP_MAX = 5'd6;

  // Op is kept as raw bits so codes 5..7 can be latched and echoed back.
  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vpn;
  } TlbMaintReqSt;

  // The search index depends on the TLB size, so it lives outside this record.
  typedef struct packed {
    logic        err;
    logic        found;
    logic [31:0] ehi;
    logic [31:0] elo0;
    logic [31:0] elo1;
    logic [31:0] tlbidx;
    logic [9:0]  asid;
  } TlbMaintRspSt;

  function automatic logic req_illegal(input TlbMaintReqSt r);
    return (r.op > 3'(OP_INV)) ||
           ((r.op == 3'(OP_INV)) && (r.inv_op > INVTLB_OP_MAX));
  endfunction

  function automatic logic op_modifies_tlb(input logic [2:0] op);
    return (op == 3'(OP_WR)) || (op == 3'(OP_FILL)) || (op == 3'(OP_INV));
  endfunction

endpackage

// File: rtl/tlb_maint_ctrl_if.sv
// Commit-stage <-> maintenance-sequencer request/response bundle.
// req_*: op + INVTLB operands with valid/ready; rsp_*: result fields with valid/ready.
// Names carry the controller's point of view (_i into it, _o out of it).
interface tlb_maint_ctrl_if #(
  parameter int IDX_W = 5
) ();
  import tlb_maint_ctrl_pkg::*;

  logic              req_valid_i;
  logic              req_ready_o;
  logic [2:0]        req_op_i;
  logic [4:0]        req_inv_op_i;
  logic [9:0]        req_inv_asid_i;
  logic [18:0]       req_inv_vpn_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [2:0]        rsp_op_o;
  logic              rsp_err_o;
  logic              rsp_found_o;
  logic [IDX_W-1:0]  rsp_idx_o;
  logic [31:0]       rsp_ehi_o;
  logic [31:0]       rsp_elo0_o;
  logic [31:0]       rsp_elo1_o;
  logic [31:0]       rsp_tlbidx_o;
  logic [9:0]        rsp_asid_o;

  modport master (
    output req_valid_i, req_op_i, req_inv_op_i, req_inv_asid_i, req_inv_vpn_i,
    output rsp_ready_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_op_o, rsp_err_o, rsp_found_o, rsp_idx_o,
    input  rsp_ehi_o, rsp_elo0_o, rsp_elo1_o, rsp_tlbidx_o, rsp_asid_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_inv_op_i, req_inv_asid_i, req_inv_vpn_i,
    input  rsp_ready_i,
    output req_ready_o,
    output rsp_valid_o, rsp_op_o, rsp_err_o, rsp_found_o, rsp_idx_o,
    output rsp_ehi_o, rsp_elo0_o, rsp_elo1_o, rsp_tlbidx_o, rsp_asid_o
  );

endinterface

// File: rtl/tlb_rand_lfsr.sv
// Free-running Fibonacci LFSR supplying TLBFILL victim indices.
// Latency: new value every clock; no handshake, never stalls.
// Ports: clk, a_rst_n (async, active low, seeds 1), value_o (current state, never 0).
module tlb_rand_lfsr
  import tlb_maint_ctrl_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             a_rst_n,
  output logic [IDX_W-1:0] value_o
);

  logic [IDX_W-1:0] lfsr_q;
  logic [IDX_W-1:0] lfsr_d;
  logic             fb;

  // Maximal-length taps: x^4+x^3+1, x^5+x^3+1, x^6+x^5+1.
  if (IDX_W == 4) begin : g_taps4
    assign fb = lfsr_q[3] ^ lfsr_q[2];
  end else if (IDX_W == 6) begin : g_taps6
    assign fb = lfsr_q[5] ^ lfsr_q[4];
  end else begin : g_taps5
    assign fb = lfsr_q[4] ^ lfsr_q[2];
  end

  assign lfsr_d  = {lfsr_q[IDX_W-2:0], fb};
  assign value_o = lfsr_q;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      lfsr_q <= {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/tlb_maint_ctrl.sv
// Sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB onto the MMU maintenance ports.
// Latency: strobe 1 cycle after accept, response 3 cycles after (1 on illegal op).
// Backpressure: one op in flight; req_ready_o low until the response is taken.
// Ports: clk/a_rst_n; bus (slave: request in, response out); MMU strobes,
// fill index and INVTLB operands out; MMU search/read results in; refetch_o pulse.
module tlb_maint_ctrl
  import tlb_maint_ctrl_pkg::*;
#(
  parameter  int TLB_ENTRY_NUM = 32,
  localparam int IDX_W         = $clog2(TLB_ENTRY_NUM)
) (
  input  logic             clk,
  input  logic             a_rst_n,
  tlb_maint_ctrl_if.slave  bus,

  output logic             tlbsrch_en_o,
  output logic             tlbwr_en_o,
  output logic             tlbfill_en_o,
  output logic             invtlb_en_o,
  output logic [IDX_W-1:0] rand_idx_o,
  output logic [4:0]       invtlb_op_o,
  output logic [9:0]       invtlb_asid_o,
  output logic [18:0]      invtlb_vpn_o,

  input  logic             tlbsrch_found_i,
  input  logic [IDX_W-1:0] tlbsrch_idx_i,
  input  logic [31:0]      rd_ehi_i,
  input  logic [31:0]      rd_elo0_i,
  input  logic [31:0]      rd_elo1_i,
  input  logic [31:0]      rd_idx_i,
  input  logic [9:0]       rd_asid_i,

  output logic             refetch_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]       state_q, state_d;
  TlbMaintReqSt     req_q, req_d, req_in;
  TlbMaintRspSt     rsp_q, rsp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rand_q, rand_d;
  logic [IDX_W-1:0] lfsr_val;

  tlb_rand_lfsr #(.IDX_W(IDX_W)) u_lfsr (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .value_o (lfsr_val)
  );

  always_comb begin
    req_in          = '0;
    req_in.op       = bus.req_op_i;
    req_in.inv_op   = bus.req_inv_op_i;
    req_in.inv_asid = bus.req_inv_asid_i;
    req_in.inv_vpn  = bus.req_inv_vpn_i;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    idx_d   = idx_q;
    rand_d  = rand_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          req_d  = req_in;
          // Fill index is frozen here so the MMU sees a stable value in EXEC.
          rand_d = lfsr_val;
          // Clearing on accept makes every field the op does not write read 0.
          rsp_d  = '0;
          idx_d  = '0;
          if (req_illegal(req_in)) begin
            rsp_d.err = 1'b1;
            state_d   = ST_RESP;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: state_d = ST_CAPT;
      ST_CAPT: begin
        state_d = ST_RESP;
        if (req_q.op == 3'(OP_SRCH)) begin
          rsp_d.found = tlbsrch_found_i;
          idx_d       = tlbsrch_idx_i;
        end else if (req_q.op == 3'(OP_RD)) begin
          rsp_d.ehi    = rd_ehi_i;
          rsp_d.elo0   = rd_elo0_i;
          rsp_d.elo1   = rd_elo1_i;
          rsp_d.tlbidx = rd_idx_i;
          rsp_d.asid   = rd_asid_i;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
      idx_q   <= '0;
      rand_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      idx_q   <= idx_d;
      rand_q  <= rand_d;
    end
  end

  // Strobes decode straight from state so the async reset kills them at once.
  logic in_exec, in_resp;
  assign in_exec = (state_q == ST_EXEC);
  assign in_resp = (state_q == ST_RESP);

  assign tlbsrch_en_o  = in_exec && (req_q.op == 3'(OP_SRCH));
  assign tlbwr_en_o    = in_exec && (req_q.op == 3'(OP_WR));
  assign tlbfill_en_o  = in_exec && (req_q.op == 3'(OP_FILL));
  assign invtlb_en_o   = in_exec && (req_q.op == 3'(OP_INV));

  assign rand_idx_o    = tlbfill_en_o ? rand_q        : '0;
  assign invtlb_op_o   = invtlb_en_o  ? req_q.inv_op   : '0;
  assign invtlb_asid_o = invtlb_en_o  ? req_q.inv_asid : '0;
  assign invtlb_vpn_o  = invtlb_en_o  ? req_q.inv_vpn  : '0;

  assign refetch_o     = (state_q == ST_CAPT) && op_modifies_tlb(req_q.op);

  assign bus.req_ready_o  = (state_q == ST_IDLE);
  assign bus.rsp_valid_o  = in_resp;
  assign bus.rsp_op_o     = in_resp ? req_q.op     : '0;
  assign bus.rsp_err_o    = in_resp ? rsp_q.err    : 1'b0;
  assign bus.rsp_found_o  = in_resp ? rsp_q.found  : 1'b0;
  assign bus.rsp_idx_o    = in_resp ? idx_q        : '0;
  assign bus.rsp_ehi_o    = in_resp ? rsp_q.ehi    : '0;
  assign bus.rsp_elo0_o   = in_resp ? rsp_q.elo0   : '0;
  assign bus.rsp_elo1_o   = in_resp ? rsp_q.elo1   : '0;
  assign bus.rsp_tlbidx_o = in_resp ? rsp_q.tlbidx : '0;
  assign bus.rsp_asid_o   = in_resp ? rsp_q.asid   : '0;

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Directed bench for tlb_maint_ctrl: vector table plus backpressure and
// mid-op reset sequences. Outputs are sampled on the falling clock edge.
module tb_tlb_maint_ctrl;

  logic clk = 1'b0;
  logic a_rst_n = 1'b0;
  always #5 clk = ~clk;

  tlb_maint_ctrl_if #(.IDX_W(5)) bus ();

  logic        tlbsrch_en_o, tlbwr_en_o, tlbfill_en_o, invtlb_en_o;
  logic [4:0]  rand_idx_o;
  logic [4:0]  invtlb_op_o;
  logic [9:0]  invtlb_asid_o;
  logic [18:0] invtlb_vpn_o;
  logic        tlbsrch_found_i;
  logic [4:0]  tlbsrch_idx_i;
  logic [31:0] rd_ehi_i, rd_elo0_i, rd_elo1_i, rd_idx_i;
  logic [9:0]  rd_asid_i;
  logic        refetch_o;

  tlb_maint_ctrl #(.TLB_ENTRY_NUM(32)) dut (
    .clk             (clk),
    .a_rst_n         (a_rst_n),
    .bus             (bus.slave),
    .tlbsrch_en_o    (tlbsrch_en_o),
    .tlbwr_en_o      (tlbwr_en_o),
    .tlbfill_en_o    (tlbfill_en_o),
    .invtlb_en_o     (invtlb_en_o),
    .rand_idx_o      (rand_idx_o),
    .invtlb_op_o     (invtlb_op_o),
    .invtlb_asid_o   (invtlb_asid_o),
    .invtlb_vpn_o    (invtlb_vpn_o),
    .tlbsrch_found_i (tlbsrch_found_i),
    .tlbsrch_idx_i   (tlbsrch_idx_i),
    .rd_ehi_i        (rd_ehi_i),
    .rd_elo0_i       (rd_elo0_i),
    .rd_elo1_i       (rd_elo1_i),
    .rd_idx_i        (rd_idx_i),
    .rd_asid_i       (rd_asid_i),
    .refetch_o       (refetch_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc;

  // x^5+x^3+1 sequence from seed 1, worked out by hand.
  int lfsr_seq [31] = '{1, 2, 4, 9, 18, 5, 11, 22, 12, 25, 19, 7, 15, 31, 30, 28,
                        24, 17, 3, 6, 13, 27, 23, 14, 29, 26, 21, 10, 20, 8, 16};

  // Rising edges since reset release; the DUT LFSR steps on the same edges.
  always @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  inv_op;
    logic [9:0]  asid;
    logic [18:0] vpn;
    logic        found;
    logic [4:0]  sidx;
    logic [31:0] ehi, elo0, elo1, ridx;
    logic [9:0]  rasid;
    logic        e_err;
    logic        e_found;
    logic [4:0]  e_idx;
    logic [31:0] e_ehi, e_elo0, e_elo1, e_tlbidx;
    logic [9:0]  e_asid;
    logic [3:0]  e_stb;   // {srch, wr, fill, inv}
    logic        e_ref;
  } vec_t;

  localparam int NV = 13;
  vec_t tv [NV];

  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] JE = 32'hDEAD_BEEF;
  localparam logic [31:0] J0 = 32'hCAFE_0001;
  localparam logic [31:0] J1 = 32'hCAFE_0002;
  localparam logic [31:0] JI = 32'h0000_001F;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] stb();
    return {tlbsrch_en_o, tlbwr_en_o, tlbfill_en_o, invtlb_en_o};
  endfunction

  task automatic chk_rsp(input string t, input vec_t v);
    chk({t, ".vld"},    64'(bus.rsp_valid_o),  64'(1));
    chk({t, ".op"},     64'(bus.rsp_op_o),     64'(v.op));
    chk({t, ".err"},    64'(bus.rsp_err_o),    64'(v.e_err));
    chk({t, ".found"},  64'(bus.rsp_found_o),  64'(v.e_found));
    chk({t, ".idx"},    64'(bus.rsp_idx_o),    64'(v.e_idx));
    chk({t, ".ehi"},    64'(bus.rsp_ehi_o),    64'(v.e_ehi));
    chk({t, ".elo0"},   64'(bus.rsp_elo0_o),   64'(v.e_elo0));
    chk({t, ".elo1"},   64'(bus.rsp_elo1_o),   64'(v.e_elo1));
    chk({t, ".tlbidx"}, 64'(bus.rsp_tlbidx_o), 64'(v.e_tlbidx));
    chk({t, ".asid"},   64'(bus.rsp_asid_o),   64'(v.e_asid));
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_valid_i    = 1'b1;
    bus.req_op_i       = v.op;
    bus.req_inv_op_i   = v.inv_op;
    bus.req_inv_asid_i = v.asid;
    bus.req_inv_vpn_i  = v.vpn;
    tlbsrch_found_i    = v.found;
    tlbsrch_idx_i      = v.sidx;
    rd_ehi_i           = v.ehi;
    rd_elo0_i          = v.elo0;
    rd_elo1_i          = v.elo1;
    rd_idx_i           = v.ridx;
    rd_asid_i          = v.rasid;
  endtask

  // Entered and left on a falling edge with the DUT idle; rsp_ready_i high.
  task automatic run_vec(input string t, input vec_t v);
    drive_req(v);
    chk({t, ".rdy"}, 64'(bus.req_ready_o), 64'(1));
    @(posedge clk);
    @(negedge clk);                       // cycle N+1
    bus.req_valid_i = 1'b0;
    chk({t, ".rdy1"}, 64'(bus.req_ready_o), 64'(0));
    if (v.e_err) begin
      chk({t, ".stb1"}, 64'(stb()), 64'(0));
      chk({t, ".ref1"}, 64'(refetch_o), 64'(0));
      chk_rsp({t, ".rsp"}, v);
    end else begin
      chk({t, ".stb1"},  64'(stb()), 64'(v.e_stb));
      chk({t, ".vld1"},  64'(bus.rsp_valid_o), 64'(0));
      chk({t, ".ref1"},  64'(refetch_o), 64'(0));
      chk({t, ".rand"},  64'(rand_idx_o), (v.op == 3'd3) ? 64'(lfsr_seq[(cyc - 1) % 31]) : 64'(0));
      chk({t, ".iop"},   64'(invtlb_op_o),   v.e_stb[0] ? 64'(v.inv_op) : 64'(0));
      chk({t, ".iasid"}, 64'(invtlb_asid_o), v.e_stb[0] ? 64'(v.asid)   : 64'(0));
      chk({t, ".ivpn"},  64'(invtlb_vpn_o),  v.e_stb[0] ? 64'(v.vpn)    : 64'(0));
      @(negedge clk);                     // cycle N+2
      chk({t, ".stb2"}, 64'(stb()), 64'(0));
      chk({t, ".ref2"}, 64'(refetch_o), 64'(v.e_ref));
      chk({t, ".vld2"}, 64'(bus.rsp_valid_o), 64'(0));
      chk({t, ".iop2"}, 64'(invtlb_op_o), 64'(0));
      @(negedge clk);                     // cycle N+3
      chk({t, ".ref3"}, 64'(refetch_o), 64'(0));
      chk_rsp({t, ".rsp"}, v);
    end
    @(negedge clk);
    chk({t, ".idle_vld"}, 64'(bus.rsp_valid_o), 64'(0));
    chk({t, ".idle_rdy"}, 64'(bus.req_ready_o), 64'(1));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t bp;

    tv[0]  = '{3'd0, 5'd0, 10'h0, 19'h0, 1'b1, 5'd7,  JE, J0, J1, JI, 10'h3FF,
               1'b0, 1'b1, 5'd7, Z, Z, Z, Z, 10'h0, 4'b1000, 1'b0};
    tv[1]  = '{3'd0, 5'd0, 10'h0, 19'h0, 1'b0, 5'd3,  JE, J0, J1, JI, 10'h3FF,
               1'b0, 1'b0, 5'd3, Z, Z, Z, Z, 10'h0, 4'b1000, 1'b0};
    tv[2]  = '{3'd1, 5'd0, 10'h0, 19'h0, 1'b1, 5'd21,
               32'h1234_6000, 32'h0001_2A5F, 32'h0001_2B5F, 32'h0600_0004, 10'h05A,
               1'b0, 1'b0, 5'd0,
               32'h1234_6000, 32'h0001_2A5F, 32'h0001_2B5F, 32'h0600_0004, 10'h05A,
               4'b0000, 1'b0};
    tv[3]  = '{3'd1, 5'd0, 10'h0, 19'h0, 1'b1, 5'd21, Z, Z, Z, 32'h8000_0011, 10'h001,
               1'b0, 1'b0, 5'd0, Z, Z, Z, 32'h8000_0011, 10'h001, 4'b0000, 1'b0};
    tv[4]  = '{3'd2, 5'd0, 10'h0, 19'h0, 1'b1, 5'd21, JE, J0, J1, JI, 10'h3FF,
               1'b0, 1'b0, 5'd0, Z, Z, Z, Z, 10'h0, 4'b0100, 1'b1};
    tv[5]  = '{3'd3, 5'd0, 10'h0, 19'h0, 1'b1, 5'd21, JE, J0, J1, JI, 10'h3FF,
               1'b0, 1'b0, 5'd0, Z, Z, Z, Z, 10'h0, 4'b0010, 1'b1};
    tv[6]  = tv[5];
    tv[7]  = '{3'd4, 5'd5, 10'h003, 19'h1_2345, 1'b1, 5'd21, JE, J0, J1, JI, 10'h3FF,
               1'b0, 1'b0, 5'd0, Z, Z, Z, Z, 10'h0, 4'b0001, 1'b1};
    tv[8]  = '{3'd4, 5'd6, 10'h155, 19'h7_FFFF, 1'b1, 5'd21, JE, J0, J1, JI, 10'h3FF,
               1'b0, 1'b0, 5'd0, Z, Z, Z, Z, 10'h0, 4'b0001, 1'b1};
    tv[9]  = '{3'd4, 5'd7, 10'h003, 19'h1_2345, 1'b1, 5'd21, JE, J0, J1, JI, 10'h3FF,
               1'b1, 1'b0, 5'd0, Z, Z, Z, Z, 10'h0, 4'b0000, 1'b0};
    tv[10] = '{3'd5, 5'd0, 10'h0, 19'h0, 1'b1, 5'd21, JE, J0, J1, JI, 10'h3FF,
               1'b1, 1'b0, 5'd0, Z, Z, Z, Z, 10'h0, 4'b0000, 1'b0};
    tv[11] = '{3'd7, 5'd0, 10'h0, 19'h0, 1'b1, 5'd21, JE, J0, J1, JI, 10'h3FF,
               1'b1, 1'b0, 5'd0, Z, Z, Z, Z, 10'h0, 4'b0000, 1'b0};
    tv[12] = '{3'd4, 5'd31, 10'h0, 19'h0, 1'b1, 5'd21, JE, J0, J1, JI, 10'h3FF,
               1'b1, 1'b0, 5'd0, Z, Z, Z, Z, 10'h0, 4'b0000, 1'b0};

    bus.req_valid_i = 1'b0;
    bus.req_op_i = '0; bus.req_inv_op_i = '0; bus.req_inv_asid_i = '0; bus.req_inv_vpn_i = '0;
    bus.rsp_ready_i = 1'b1;
    tlbsrch_found_i = 1'b0; tlbsrch_idx_i = '0;
    rd_ehi_i = '0; rd_elo0_i = '0; rd_elo1_i = '0; rd_idx_i = '0; rd_asid_i = '0;

    // Reset state
    #12;
    chk("rst.stb",   64'(stb()), 64'(0));
    chk("rst.vld",   64'(bus.rsp_valid_o), 64'(0));
    chk("rst.rand",  64'(rand_idx_o), 64'(0));
    chk("rst.ref",   64'(refetch_o), 64'(0));
    chk("rst.iop",   64'(invtlb_op_o), 64'(0));
    @(negedge clk);
    a_rst_n = 1'b1;
    @(negedge clk);
    chk("rel.rdy",   64'(bus.req_ready_o), 64'(1));
    chk("rel.vld",   64'(bus.rsp_valid_o), 64'(0));

    // Back-to-back table vectors at the 4-cycle initiation interval
    for (int i = 0; i < NV; i++) begin
      run_vec($sformatf("v%0d", i), tv[i]);
    end

    // Backpressure: response held for 10 cycles while a new request is offered
    bp = tv[0];
    bp.sidx = 5'd12;
    bp.e_idx = 5'd12;
    bus.rsp_ready_i = 1'b0;
    drive_req(bp);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      if (k == 1) begin
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 3'd2;
        tlbsrch_found_i = 1'b0;
        tlbsrch_idx_i   = 5'd1;
      end
      chk_rsp($sformatf("bp%0d", k), bp);
      chk($sformatf("bp%0d.rdy", k), 64'(bus.req_ready_o), 64'(0));
      chk($sformatf("bp%0d.stb", k), 64'(stb()), 64'(0));
      @(negedge clk);
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp.done_vld", 64'(bus.rsp_valid_o), 64'(0));
    chk("bp.done_rdy", 64'(bus.req_ready_o), 64'(1));
    @(negedge clk);
    chk("bp.no_accept", 64'(stb()), 64'(0));
    chk("bp.no_accept_rdy", 64'(bus.req_ready_o), 64'(1));

    // Reset while a TLBWR strobe is in progress
    drive_req(tv[4]);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("rx.wr_before", 64'(tlbwr_en_o), 64'(1));
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("rx.wr_dropped", 64'(tlbwr_en_o), 64'(0));
    chk("rx.stb", 64'(stb()), 64'(0));
    @(negedge clk);
    a_rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rx%0d.rdy", k), 64'(bus.req_ready_o), 64'(1));
      chk($sformatf("rx%0d.vld", k), 64'(bus.rsp_valid_o), 64'(0));
      chk($sformatf("rx%0d.ref", k), 64'(refetch_o), 64'(0));
      chk($sformatf("rx%0d.stb", k), 64'(stb()), 64'(0));
    end

    // Service resumes after reset, including a fresh LFSR sequence
    run_vec("post_srch", tv[0]);
    run_vec("post_fill", tv[5]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlb_maint_ctrl.md
# tlb_maint_ctrl

Sequences TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) from the commit stage onto the memory management unit's maintenance ports. It accepts one operation at a time through a valid/ready handshake and strobes the MMU enables for exactly one cycle. It captures search and read results and returns them to the CSR file. Operations that modify the TLB raise a pipeline refetch pulse.

## Interface
- `TLB_ENTRY_NUM`, 32: TLB entries; `IDX_W = $clog2(TLB_ENTRY_NUM)`, supported for 16/32/64 entries.
- `clk` in 1: clock.
- `a_rst_n` in 1: asynchronous reset, active low; one clock, async active-low reset, as decided.
- `req_valid_i` in 1, `req_ready_o` out 1: request handshake.
- `req_op_i` in 3: operation code; 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5–7 illegal.
- `req_inv_op_i` in 5, `req_inv_asid_i` in 10, `req_inv_vpn_i` in 19: INVTLB operands.
- `tlbsrch_en_o`, `tlbwr_en_o`, `tlbfill_en_o`, `invtlb_en_o` out 1: one-cycle MMU strobes.
- `rand_idx_o` out IDX_W: fill index.
- `invtlb_op_o` out 5, `invtlb_asid_o` out 10, `invtlb_vpn_o` out 19: registered INVTLB operands.
- `tlbsrch_found_i` in 1, `tlbsrch_idx_i` in IDX_W: MMU search result.
- `rd_ehi_i`, `rd_elo0_i`, `rd_elo1_i`, `rd_idx_i` in 32, `rd_asid_i` in 10: MMU read result (combinational from CSR index).
- `rsp_valid_o` out 1, `rsp_ready_i` in 1: response handshake.
- `rsp_op_o` out 3, `rsp_err_o` out 1, `rsp_found_o` out 1, `rsp_idx_o` out IDX_W: response fields.
- `rsp_ehi_o`, `rsp_elo0_o`, `rsp_elo1_o`, `rsp_tlbidx_o` out 32, `rsp_asid_o` out 10: response fields.
- `refetch_o` out 1: one-cycle pulse requesting a front-end flush and refetch.

## Operation
- FSM states IDLE, EXEC, CAPT, RESP.
- **IDLE**
  - `req_ready_o = 1`.
  - On `req_valid_i`, latch op and operands.
  - An illegal op, or INV with `req_inv_op_i > 6`, goes directly to RESP with `rsp_err_o = 1` and no strobe.
  - Otherwise go to EXEC.
- **EXEC** (1 cycle)
  - Assert exactly the strobe matching the op.
  - RD asserts no strobe; the MMU read path is combinational.
  - FILL drives `rand_idx_o` = LFSR value frozen at EXEC entry.
- **CAPT** (1 cycle)
  - SRCH: register `tlbsrch_found_i` and `tlbsrch_idx_i`.
  - RD: register all `rd_*` inputs.
  - WR/FILL/INV: capture nothing; pulse `refetch_o`.
- **RESP**: hold `rsp_valid_o` and all `rsp_*` stable until `rsp_ready_i`, then return to IDLE.
- **Response fields**
  - Fields not written by the current op read 0.
  - `rsp_op_o` always echoes the op.
- **LFSR**
  - IDX_W-bit Fibonacci LFSR, free-running every cycle, reset seed 1, never 0.
  - Taps: x^4+x^3+1, x^5+x^3+1, x^6+x^5+1.
- **Single outstanding op**: `req_ready_o = 0` outside IDLE.
- **Reset**: asynchronous reset at any state forces IDLE, all strobes and outputs 0, LFSR to 1; an in-flight op is dropped and gets no response.

## Timing
- Request accepted at edge N.
- Strobe asserted in cycle N+1.
- Capture at edge N+2; `refetch_o` high in cycle N+2.
- `rsp_valid_o` from cycle N+3.
- Error path: `rsp_valid_o` from cycle N+1.
- Minimum initiation interval: 4 cycles with `rsp_ready_i` held high.
- Strobes are never high for more than one cycle, never two at once, never while `a_rst_n` is low.
- Invalid-index RD still completes; the MMU reports `rd_idx_i[31]` (NE), passed through.
- Reset values:
  - `req_ready_o` = 1 after reset deassert.
  - All other outputs = 0, except `rand_idx_o` = 0 (not driven from LFSR outside EXEC).

## Structure
- Shared package (`MemoryManagementUnit.svh`):
  - `TlbMaintOpE` enum (values above).
  - `TlbMaintReqSt` (op + INV operands).
  - `TlbMaintRspSt` (response fields).
  - `INVTLB_OP_MAX = 6`.
- Sub-module `tlb_rand_lfsr` (params IDX_W; ports clk, a_rst_n, `value_o`).
- FSM, operand/result registers and response mux live in the top.

## Test plan
- SRCH: found=1, idx=7 returned at cycle N+2 → `tlbsrch_en_o` high in N+1 only; `rsp_valid_o` at N+3 with found=1, idx=7, `refetch_o` never high.
- RD: `rd_ehi_i`=0x1234_6000, `rd_asid_i`=0x05A → response carries the same values, err=0.
- FILL twice back-to-back after reset → `tlbfill_en_o` pulses; `rand_idx_o` equals LFSR sequence values; `refetch_o` pulses at N+2 each time.
- INV op=7 → no strobe; `rsp_err_o` = 1 at N+1. INV op=5 with asid=0x3, vpn=0x1_2345 → `invtlb_*` match for one cycle.
- Backpressure: hold `rsp_ready_i` = 0 for 10 cycles → `rsp_*` stable, `req_ready_o` = 0, new `req_valid_i` ignored.
- Reset asserted in EXEC → strobe drops immediately; after release state is IDLE, `req_ready_o` = 1, no response.
